// File: rtl/nco_sequencer_multi.sv
// nco_sequencer_multi: four-unit sawtooth NCO, time-multiplexed over a 16-clock frame per sample_tick
module nco_sequencer_multi #(
  parameter int dsz = 52
) (
  input  logic           clk50mhz,
  input  logic           reset_n,
  input  logic           sample_tick,
  input  logic [dsz-1:0] inc,
  input  logic [3:0]     sync,
  output logic [1:0]     unit,
  output logic           portamento_clk,
  output logic [15:0]    sample_out,
  output logic [1:0]     sample_unit,
  output logic           sample_valid,
  output logic           busy,
  output logic           overrun
);
  typedef enum logic [2:0] {IDLE, SEL, CAPTURE, ACCUM, EMIT} state_t;
  state_t                state_q, state_d;
  logic [1:0]            slot_q, slot_d;
  logic [dsz-1:0]        inc_q;
  logic [3:0][dsz-1:0]   phase_q;
  logic [dsz-1:0]        phase_d;
  logic [3:0]            pending_q, pending_d;
  logic [15:0]           sample_out_q;
  logic [1:0]            sample_unit_q;
  logic                  overrun_q;
  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      IDLE: begin
        state_d = sample_tick ? SEL : IDLE;
        slot_d  = sample_tick ? 2'd0 : slot_q;
      end
      SEL:     state_d = CAPTURE;
      CAPTURE: state_d = ACCUM;
      ACCUM:   state_d = EMIT;
      EMIT: begin
        state_d = (slot_q == 2'd3) ? IDLE : SEL;
        slot_d  = (slot_q == 2'd3) ? slot_q : slot_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    unit           = slot_q;
    portamento_clk = state_q == CAPTURE;
    sample_valid   = state_q == EMIT;
    busy           = state_q != IDLE;
    sample_out     = sample_out_q;
    sample_unit    = sample_unit_q;
    overrun        = overrun_q;
  end
  // A pending sync wins over the sum; a sync landing on the clearing cycle re-arms it.
  always_comb begin
    phase_d   = pending_q[slot_q] ? '0 : phase_q[slot_q] + inc_q;
    pending_d = (pending_q & ~((state_q == ACCUM) ? (4'b0001 << slot_q) : 4'b0000)) | sync;
  end
  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      inc_q         <= '0;
      phase_q       <= '0;
      pending_q     <= '0;
      sample_out_q  <= '0;
      sample_unit_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_q | (sample_tick & (state_q != IDLE));
      if (state_q == CAPTURE) inc_q <= inc;
      if (state_q == ACCUM) begin
        phase_q[slot_q] <= phase_d;
        sample_out_q    <= {~phase_d[dsz-1], phase_d[dsz-2 -: 15]};
        sample_unit_q   <= slot_q;
      end
    end
  end
endmodule
